// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALUOp classes and the control bundle.
// The control bundle travels unchanged through the ID/EX and EX/MEM latches.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_stage_register_file.sv
// 2^W x B register file, two async read ports, one write port.
// Define REGFILE_BYPASS_EN for same-cycle write-through on reads.
module register_file #(
  parameter int B = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  input  logic [W-1:0] raddr1,
  input  logic [W-1:0] raddr2,
  output logic [B-1:0] rdata1,
  output logic [B-1:0] rdata2
);

  logic [B-1:0] regs [2**W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**W; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
`else
`endif
    // r0 and the reset window always read zero, even over a bypass hit
    if (!reset || raddr1 == '0) rdata1 = '0;
    if (!reset || raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: regfile, control decode, sign-extend, load-use stall.
// REGFILE_BYPASS_EN selects regfile write-through on same-cycle reads.
module decode_stage
  import decode_pkg::*;
#(
  parameter int B     = 32,
  parameter int W     = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [B-1:0]     instruction_in,
  input  logic [B-1:0]     pc_next_in,
  input  logic             wb_RegWrite_in,
  input  logic [W-1:0]     wb_write_reg_in,
  input  logic [B-1:0]     wb_write_data_in,
  input  logic             id_ex_MemRead_in,
  input  logic [W-1:0]     id_ex_rt_in,
  output logic [B-1:0]     pc_next_out,
  output logic [B-1:0]     r_data1_out,
  output logic [B-1:0]     r_data2_out,
  output logic [B-1:0]     sign_ext_out,
  output logic [W-1:0]     inst_20_16_out,
  output logic [W-1:0]     inst_15_11_out,
  output logic             wb_RegWrite_out,
  output logic             wb_MemtoReg_out,
  output logic             m_Branch_out,
  output logic             m_MemRead_out,
  output logic             m_MemWrite_out,
  output logic             ex_RegDst_out,
  output logic             ex_ALUSrc_out,
  output logic [1:0]       ex_ALUOp_out,
  output logic             pc_write_out,
  output logic             if_id_write_out,
  output logic [CNT_W-1:0] stall_count_out
);

  logic [5:0]   opcode;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         stall;
  ctrl_t        ctrl;
  ctrl_t        ctrl_q;
  logic [CNT_W-1:0] cnt;

  assign opcode = instruction_in[31:26];
  assign rs     = instruction_in[25:21];
  assign rt     = instruction_in[20:16];

  register_file #(.B(B), .W(W)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_RegWrite_in),
    .waddr  (wb_write_reg_in),
    .wdata  (wb_write_data_in),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (r_data1_out),
    .rdata2 (r_data2_out)
  );

  always_comb begin
    ctrl = CTRL_NOP;
    unique case (1'b1)
      opcode == OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      opcode == OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      opcode == OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      opcode == OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      opcode == OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: ;
    endcase
  end

  assign stall = id_ex_MemRead_in
               & ((id_ex_rt_in == rs) | (id_ex_rt_in == rt))
               & (id_ex_rt_in != '0);

  assign ctrl_q = stall ? CTRL_NOP : ctrl;

  assign wb_RegWrite_out = ctrl_q.reg_write;
  assign wb_MemtoReg_out = ctrl_q.mem_to_reg;
  assign m_Branch_out    = ctrl_q.branch;
  assign m_MemRead_out   = ctrl_q.mem_read;
  assign m_MemWrite_out  = ctrl_q.mem_write;
  assign ex_RegDst_out   = ctrl_q.reg_dst;
  assign ex_ALUSrc_out   = ctrl_q.alu_src;
  assign ex_ALUOp_out    = ctrl_q.alu_op;

  assign pc_write_out    = ~stall;
  assign if_id_write_out = ~stall;

  assign pc_next_out    = pc_next_in;
  assign sign_ext_out   = {{(B-16){instruction_in[15]}}, instruction_in[15:0]};
  assign inst_20_16_out = instruction_in[20:16];
  assign inst_15_11_out = instruction_in[15:11];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (stall && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stall_count_out = cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage against a behavioural model.
// Directed steps plus a randomized burst; CNT_W reduced for saturation.
module tb_decode_stage;

  localparam int B     = 32;
  localparam int W     = 5;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [B-1:0]     instruction_in;
  logic [B-1:0]     pc_next_in;
  logic             wb_RegWrite_in;
  logic [W-1:0]     wb_write_reg_in;
  logic [B-1:0]     wb_write_data_in;
  logic             id_ex_MemRead_in;
  logic [W-1:0]     id_ex_rt_in;
  logic [B-1:0]     pc_next_out;
  logic [B-1:0]     r_data1_out;
  logic [B-1:0]     r_data2_out;
  logic [B-1:0]     sign_ext_out;
  logic [W-1:0]     inst_20_16_out;
  logic [W-1:0]     inst_15_11_out;
  logic             wb_RegWrite_out;
  logic             wb_MemtoReg_out;
  logic             m_Branch_out;
  logic             m_MemRead_out;
  logic             m_MemWrite_out;
  logic             ex_RegDst_out;
  logic             ex_ALUSrc_out;
  logic [1:0]       ex_ALUOp_out;
  logic             pc_write_out;
  logic             if_id_write_out;
  logic [CNT_W-1:0] stall_count_out;

  decode_stage #(.B(B), .W(W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .instruction_in   (instruction_in),
    .pc_next_in       (pc_next_in),
    .wb_RegWrite_in   (wb_RegWrite_in),
    .wb_write_reg_in  (wb_write_reg_in),
    .wb_write_data_in (wb_write_data_in),
    .id_ex_MemRead_in (id_ex_MemRead_in),
    .id_ex_rt_in      (id_ex_rt_in),
    .pc_next_out      (pc_next_out),
    .r_data1_out      (r_data1_out),
    .r_data2_out      (r_data2_out),
    .sign_ext_out     (sign_ext_out),
    .inst_20_16_out   (inst_20_16_out),
    .inst_15_11_out   (inst_15_11_out),
    .wb_RegWrite_out  (wb_RegWrite_out),
    .wb_MemtoReg_out  (wb_MemtoReg_out),
    .m_Branch_out     (m_Branch_out),
    .m_MemRead_out    (m_MemRead_out),
    .m_MemWrite_out   (m_MemWrite_out),
    .ex_RegDst_out    (ex_RegDst_out),
    .ex_ALUSrc_out    (ex_ALUSrc_out),
    .ex_ALUOp_out     (ex_ALUOp_out),
    .pc_write_out     (pc_write_out),
    .if_id_write_out  (if_id_write_out),
    .stall_count_out  (stall_count_out)
  );

  int passed = 0;
  int total  = 0;
  logic [31:0] mdl [32];
  int m_cnt;

  // {RegWrite,MemtoReg,Branch,MemRead,MemWrite,RegDst,ALUSrc,ALUOp}
  function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b1_0_0_0_0_1_0_10;
      6'h23:   return 9'b1_1_0_1_0_0_1_00;
      6'h2B:   return 9'b0_0_0_0_1_0_1_00;
      6'h04:   return 9'b0_0_1_0_0_0_0_01;
      6'h08:   return 9'b1_0_0_0_0_0_1_00;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic ref_stall();
    int ex_rt, s, t;
    ex_rt = int'(id_ex_rt_in);
    s = int'(instruction_in[25:21]);
    t = int'(instruction_in[20:16]);
    return id_ex_MemRead_in && ex_rt != 0 && (ex_rt == s || ex_rt == t);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (!reset || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wb_RegWrite_in && wb_write_reg_in == a) return wb_write_data_in;
`endif
    return mdl[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic st;
    logic [8:0] c;
    logic [31:0] se;
    st = ref_stall();
    c  = st ? 9'b0 : ref_ctrl(instruction_in[31:26]);
    se = 32'(signed'(instruction_in[15:0]));
    chk({tag, ".pc"}, pc_next_out, pc_next_in);
    chk({tag, ".rd1"}, r_data1_out, ref_read(instruction_in[25:21]));
    chk({tag, ".rd2"}, r_data2_out, ref_read(instruction_in[20:16]));
    chk({tag, ".sext"}, sign_ext_out, se);
    chk({tag, ".rt"}, 32'(inst_20_16_out), 32'(instruction_in[20:16]));
    chk({tag, ".rd"}, 32'(inst_15_11_out), 32'(instruction_in[15:11]));
    chk({tag, ".ctrl"},
        32'({wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out,
             m_MemRead_out, m_MemWrite_out, ex_RegDst_out,
             ex_ALUSrc_out, ex_ALUOp_out}), 32'(c));
    chk({tag, ".pcw"}, 32'(pc_write_out), 32'(!st));
    chk({tag, ".ifw"}, 32'(if_id_write_out), 32'(!st));
    chk({tag, ".cnt"}, 32'(stall_count_out), 32'(m_cnt));
  endtask

  task automatic tick();
    if (reset) begin
      if (ref_stall() && m_cnt < SAT) m_cnt++;
      if (wb_RegWrite_in && wb_write_reg_in != 5'd0)
        mdl[wb_write_reg_in] = wb_write_data_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd,
                       input logic mr, input logic [4:0] ert);
    instruction_in   = ins;
    wb_RegWrite_in   = we;
    wb_write_reg_in  = wr;
    wb_write_data_in = wd;
    id_ex_MemRead_in = mr;
    id_ex_rt_in      = ert;
    pc_next_in       = $urandom;
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    m_cnt = 0;
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [31:0] old7;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
    ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h3F;
    model_reset();
    reset = 1'b0;
    drive(32'h8D28FFFC, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_all("reset_lw");
    chk("reset_cnt", 32'(stall_count_out), 32'h0);
    chk("reset_ctrl_lw", 32'(wb_MemtoReg_out), 32'h1);

    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    tick();
    drive(32'h00A00000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_all("rd_r5");
    chk("rd_r5_val", r_data1_out, 32'hDEADBEEF);
    drive(32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    tick();
    drive(32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    check_all("rd_r0");
    chk("rd_r0_val", r_data1_out, 32'h0);

    drive(32'h8D28FFFC, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check_all("lw");
    chk("lw_sext", sign_ext_out, 32'hFFFFFFFC);
    chk("lw_rt", 32'(inst_20_16_out), 32'd8);
    chk("lw_ctrl",
        32'({wb_RegWrite_out, wb_MemtoReg_out, m_MemRead_out,
             ex_ALUSrc_out, ex_ALUOp_out}), 32'b1111_00);

    for (int i = 0; i < 6; i++) begin
      drive({ops[i], 26'h0A5_1234}, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      check_all($sformatf("op%0h", ops[i]));
    end
    drive(32'hFC00_0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("op3f_zero",
        32'({wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out,
             m_MemRead_out, m_MemWrite_out, ex_RegDst_out,
             ex_ALUSrc_out, ex_ALUOp_out}), 32'h0);

    old7 = 32'h1111_1111;
    drive(32'h0, 1'b1, 5'd7, old7, 1'b0, 5'd0);
    tick();
    drive(32'h0007_0000, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
    check_all("byp");
`ifdef REGFILE_BYPASS_EN
    chk("byp_rt7", r_data2_out, 32'hA5A5A5A5);
`else
    chk("byp_rt7", r_data2_out, old7);
`endif
    tick();
    drive(32'h0007_0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("byp_after", r_data2_out, 32'hA5A5A5A5);

    drive(32'h01095020, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8);
    check_all("haz");
    chk("haz_pcw", 32'(pc_write_out), 32'h0);
    chk("haz_regdst", 32'(ex_RegDst_out), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_all("haz_hold");
      chk("haz_cnt", 32'(stall_count_out), 32'(i));
    end
    drive(32'h00095020, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    check_all("haz_r0");
    chk("haz_r0_pcw", 32'(pc_write_out), 32'h1);
    tick();
    chk("haz_r0_cnt", 32'(stall_count_out), 32'd3);

    for (int i = 0; i < 300; i++) begin
      drive({ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 16'($urandom)},
            1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
      check_all("rand");
      tick();
    end

    drive(32'h01095020, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) tick();
    check_all("sat");
    chk("sat_cnt", 32'(stall_count_out), 32'(SAT));

    reset = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid");
    chk("rst_mid_cnt", 32'(stall_count_out), 32'h0);
    chk("rst_mid_rd1", r_data1_out, 32'h0);
    chk("rst_mid_pcw", 32'(pc_write_out), 32'h0);
    tick();
    reset = 1'b1;
    #1;
    check_all("rst_rel");
    tick();
    check_all("rst_rel2");
    chk("rst_rel2_cnt", 32'(stall_count_out), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the 5-stage MIPS pipeline, between the IF/ID latch and the ID/EX latch. It holds the 32-entry register file and decodes the main control word. It sign-extends the immediate and detects load-use hazards, inserting a bubble and freezing PC and IF/ID when one is found. All outputs drive the ID/EX latch inputs directly, except the stall enables, which go to the PC and IF/ID latch.

## Interface
- B, 32, data/instruction width
- W, 5, register-address width (register file depth = 2^W)
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears register file and stall counter
- instruction_in  in  B  instruction from IF/ID
- pc_next_in  in  B  PC+4 from IF/ID
- wb_RegWrite_in  in  1  write-back enable from MEM/WB
- wb_write_reg_in  in  W  write-back destination register
- wb_write_data_in  in  B  write-back data
- id_ex_MemRead_in  in  1  MemRead of the instruction currently in ID/EX
- id_ex_rt_in  in  W  rt field of the instruction currently in ID/EX
- pc_next_out  out  B  equal to pc_next_in
- r_data1_out, r_data2_out  out  B  register file reads at rs and rt
- sign_ext_out  out  B  sign-extended instruction[15:0]
- inst_20_16_out, inst_15_11_out  out  W  rt and rd fields
- wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out  out  1 each  control word
- ex_ALUOp_out  out  2  ALU operation class
- pc_write_out  out  1  PC update enable (0 = hold)
- if_id_write_out  out  1  IF/ID update enable (0 = hold)
- stall_count_out  out  CNT_W  saturating count of stall cycles since reset

## Operation
- Field extraction: opcode = instruction[31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0].
- Register file: 2^W × B.
  - Two combinational read ports (rs, rt) and one write port.
  - Write occurs on the rising edge when wb_RegWrite_in=1 and wb_write_reg_in≠0.
  - Register 0 always reads 0 and is never written.
- Control decode by opcode (any field not listed is 0):
  - 000000 R-type: RegDst=1, RegWrite=1, ALUOp=10.
  - 100011 lw: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00.
  - 101011 sw: ALUSrc=1, MemWrite=1, ALUOp=00.
  - 000100 beq: Branch=1, ALUOp=01.
  - 001000 addi: ALUSrc=1, RegWrite=1, ALUOp=00.
  - Any other opcode: all control 0 (treated as NOP).
- Hazard: stall = id_ex_MemRead_in & (id_ex_rt_in == rs | id_ex_rt_in == rt) & (id_ex_rt_in ≠ 0).
- When stall=1:
  - pc_write_out=0 and if_id_write_out=0.
  - All control outputs are forced to 0 (bubble).
  - Data outputs still reflect the current decode.
- When stall=0: pc_write_out=1 and if_id_write_out=1.
- Stall counter increments by 1 on each rising edge with stall=1 and saturates at 2^CNT_W−1.

## Timing
- All decode, read, sign-extend and hazard outputs are combinational from the inputs; the stage adds zero cycles of latency.
- A register write is visible to a non-bypassed read on the cycle after the write edge.
- Reset asserted (low):
  - All registers and stall_count_out go to 0 immediately.
  - Reads return 0.
  - Control outputs follow instruction_in, since decode is combinational.
- Reset deasserted: the first write edge is the next rising clk edge.
- Reset mid-stall: stall_count_out clears; the stall output still follows its inputs.
- Simultaneous write and read of the same nonzero register: behaviour is selected by the macro below.
- A write to register 0 together with a read of register 0 returns 0 in both builds.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Applies when wb_RegWrite_in=1 and wb_write_reg_in equals a nonzero read address.
  - That read port returns wb_write_data_in in the same cycle (write-through).
- REGFILE_BYPASS_EN undefined:
  - The read returns the stored (old) value.
  - Software or forwarding must cover the gap.

## Structure
- Shared package holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI.
  - ALUOp encodings: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - The control-word bundle layout, which is reused by the ID/EX and EX/MEM latches.
- One sub-module, register_file: holds the storage, the write port, the read ports and the bypass option.
- Decode, sign-extend, hazard logic and the stall counter stay in decode_stage.

## Test plan
- Reset, then write 0xDEADBEEF to r5 and read rs=5 next cycle -> r_data1_out=0xDEADBEEF. Write 0x1234 to r0, read rs=0 -> 0.
- lw r8,−4(r9) (0x8D28FFFC) -> ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00, sign_ext_out=0xFFFFFFFC, inst_20_16_out=8.
- Decode each of: add (opcode 0), sw, beq, addi, and opcode 111111 -> control words exactly as listed in Operation; 111111 gives all zeros.
- id_ex_MemRead_in=1, id_ex_rt_in=8, current instruction rs=8 -> pc_write_out=0, if_id_write_out=0, all control 0, stall_count_out +1 per cycle. Same case with id_ex_rt_in=0 -> no stall.
- Same-cycle write r7=0xA5A5A5A5 with read rt=7 -> r_data2_out=0xA5A5A5A5 with REGFILE_BYPASS_EN, previous value without.
- Hold stall for 2^CNT_W+3 cycles -> counter saturates at all-ones. Pulse reset low mid-stall -> counter and registers read 0 immediately.
